// File: rtl/uart_rx.sv
// uart_rx: 16x oversampling UART receiver (8N1) with a small receive FIFO.
// Define UART_RX_PARITY_EN for 8E1 framing with even-parity checking.
module uart_rx #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk_100mhz,
  input  logic       sys_rst,
  input  logic       uart_rxd,
  output logic [7:0] data_out,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overflow
);

  localparam int OS_DIV = CLK_FREQ / (16 * BAUD);
  localparam int OS_W   = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int PW     = AW + 1;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE, START, DATA, STOP
  } state_t;
`endif

  state_t state, state_n;

  logic meta, rx, rx_prev;
  logic fall;

  logic [OS_W-1:0] os_cnt;
  logic            tick;
  logic [3:0]      tick_cnt;
  logic [2:0]      bit_cnt;
  logic [7:0]      shreg;
  logic            at_mid, at_end;

  logic clr, shift_en, stop_en;
  logic par_fail;
`ifdef UART_RX_PARITY_EN
  logic par_en;
  logic perr_q;
`endif

  logic          push_req, push, pop, full;
  logic [PW-1:0] wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [7:0]    head_n;

  always_ff @(posedge clk_100mhz or posedge sys_rst) begin
    if (sys_rst) begin
      meta    <= 1'b1;
      rx      <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      meta    <= uart_rxd;
      rx      <= meta;
      rx_prev <= rx;
    end
  end

  assign fall   = rx_prev & ~rx;
  assign tick   = (os_cnt == OS_W'(OS_DIV - 1));
  assign at_mid = tick && (tick_cnt == 4'd7);
  assign at_end = tick && (tick_cnt == 4'd15);

  always_ff @(posedge clk_100mhz or posedge sys_rst) begin
    if (sys_rst) state <= IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n  = state;
    clr      = 1'b0;
    shift_en = 1'b0;
    stop_en  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_en   = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (fall) begin
          clr     = 1'b1;
          state_n = START;
        end
      end
      START: begin
        // Line back high at mid-start is a glitch, not a frame
        if (at_mid) begin
          clr     = 1'b1;
          state_n = rx ? IDLE : DATA;
        end
      end
      DATA: begin
        if (at_end) begin
          shift_en = 1'b1;
          if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (at_end) begin
          par_en  = 1'b1;
          state_n = STOP;
        end
      end
`endif
      STOP: begin
        if (at_end) begin
          stop_en = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_100mhz or posedge sys_rst) begin
    if (sys_rst) begin
      os_cnt   <= '0;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
    end else begin
      os_cnt <= tick ? '0 : os_cnt + OS_W'(1);
      if (clr) begin
        tick_cnt <= '0;
        bit_cnt  <= '0;
      end else if (tick) begin
        tick_cnt <= tick_cnt + 4'd1;
      end
      if (shift_en) begin
        shreg   <= {rx, shreg[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk_100mhz or posedge sys_rst) begin
    if (sys_rst) par_fail <= 1'b0;
    else if (par_en) par_fail <= (^shreg) ^ rx;
  end

  always_ff @(posedge clk_100mhz or posedge sys_rst) begin
    if (sys_rst) perr_q <= 1'b0;
    else perr_q <= stop_en & rx & par_fail;
  end

  assign parity_err = perr_q;
`else
  assign par_fail   = 1'b0;
  assign parity_err = 1'b0;
`endif

  assign push_req = stop_en & rx & ~par_fail;
  assign pop      = data_valid & data_ready;
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) &&
                    (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push     = push_req & (~full | pop);
  assign wr_ptr_n = wr_ptr + PW'(push);
  assign rd_ptr_n = rd_ptr + PW'(pop);

  // A byte landing in an empty buffer bypasses the array into the head
  always_comb begin
    head_n = mem[rd_ptr_n[AW-1:0]];
    if (push && (rd_ptr_n == wr_ptr)) head_n = shreg;
  end

  always_ff @(posedge clk_100mhz) begin
    if (push) mem[wr_ptr[AW-1:0]] <= shreg;
  end

  always_ff @(posedge clk_100mhz or posedge sys_rst) begin
    if (sys_rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      data_valid <= 1'b0;
      data_out   <= 8'h00;
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      wr_ptr     <= wr_ptr_n;
      rd_ptr     <= rd_ptr_n;
      data_valid <= (wr_ptr_n != rd_ptr_n);
      if (wr_ptr_n != rd_ptr_n) data_out <= head_n;
      frame_err  <= stop_en & ~rx;
      overflow   <= push_req & full & ~pop;
    end
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLK_FREQ, default 100_000_000: system clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200: serial bit rate.
REQ-003 Parameter FIFO_DEPTH, default 4: receive buffer entries; power of two, 2..16.
REQ-004 clk_100mhz  input  1  system clock; single clock domain; all logic on its rising edge.
REQ-005 sys_rst  input  1  asynchronous, active-high reset.
REQ-006 uart_rxd  input  1  asynchronous serial line; idle high; 8N1 framing (8E1 with UART_RX_PARITY_EN).
REQ-007 data_out  output  8  received byte at the FIFO head.
REQ-008 data_valid  output  1  FIFO non-empty; data_out is valid.
REQ-009 data_ready  input  1  consumer accepts data_out when data_valid && data_ready.
REQ-010 frame_err  output  1  one-cycle pulse on a bad stop bit.
REQ-011 parity_err  output  1  one-cycle pulse on a parity mismatch; constant 0 without UART_RX_PARITY_EN.
REQ-012 overflow  output  1  one-cycle pulse when a good byte is dropped because the FIFO is full.

Function
REQ-013 uart_rxd SHALL pass through a 2-flop synchronizer; all other logic SHALL use only the synchronized value.
REQ-014 Oversample tick: OS_DIV = CLK_FREQ/(16*BAUD) (integer truncation, 54 at defaults); a counter SHALL emit a one-cycle tick every OS_DIV cycles, free-running.
REQ-015 FSM states: IDLE, START, DATA, PARITY (only with UART_RX_PARITY_EN), STOP.
REQ-016 IDLE->START on a synchronized falling edge; the tick sub-counter SHALL clear to 0 on entry.
REQ-017 START: at tick 8, line low -> DATA; line high -> IDLE (glitch rejected; no error pulse).
REQ-018 DATA: sample every 16 ticks; LSB first into an 8-bit shift register; after bit 7 -> PARITY if enabled, else STOP.
REQ-019 PARITY: sample 16 ticks after bit 7; a mismatch SHALL latch a parity-fail flag; then -> STOP.
REQ-020 STOP: sample 16 ticks after the last bit; -> IDLE in the same cycle.
REQ-021 Stop sampled low: pulse frame_err, discard the byte, and return to IDLE; re-arm on the next falling edge only.
REQ-022 Stop high with parity fail: pulse parity_err and discard the byte.
REQ-023 Stop high, no error: push the byte into the FIFO; if the FIFO is full, drop the byte and pulse overflow instead.
REQ-024 Error pulses SHALL assert in the cycle after the stop sample and be mutually exclusive; frame_err has priority.
REQ-025 FIFO: circular buffer with pointers 1 bit wider than log2(FIFO_DEPTH); full/empty from the MSB compare; pointers wrap modulo 2*FIFO_DEPTH.
REQ-026 Latency: data_valid rises exactly 1 cycle after the push; data_out SHALL be registered FIFO head, stable while data_valid && !data_ready.
REQ-027 Simultaneous push and pop while full: the pop frees a slot, the push succeeds, and there is no overflow.
REQ-028 Simultaneous push and pop while empty: the push succeeds; data_valid rises the next cycle.
REQ-029 A pop while !data_valid SHALL be ignored.

Reset
REQ-030 On sys_rst assertion, asynchronously: FSM=IDLE, synchronizer flops=1, counters=0, FIFO pointers=0, data_out=8'h00, and data_valid, frame_err, parity_err, overflow=0.
REQ-031 Reset mid-frame SHALL abandon the partial byte; after release, reception SHALL begin at the next falling edge.

Configuration
REQ-032 Macro UART_RX_PARITY_EN defined: PARITY state exists, even parity over the 8 data bits, 11-bit frame, parity_err live.
REQ-033 UART_RX_PARITY_EN undefined: no PARITY state, 10-bit frame, parity_err tied 0.

Verification
REQ-034 Send 8'hA5 at 115200 with data_ready=1 -> a single data_valid cycle with data_out=8'hA5; no error pulses.
REQ-035 Low glitch of 3 us (< half bit) on an idle line -> no data_valid, no errors, FSM back in IDLE.
REQ-036 Send 8'h3C with stop bit forced 0 -> frame_err pulses once, FIFO stays empty, a following 8'h11 is received correctly.
REQ-037 data_ready=0, send 8'h01..8'h05 -> 4 bytes held, overflow pulses on 8'h05; raising data_ready drains 01,02,03,04 in order.
REQ-038 Assert sys_rst during bit 4 of 8'hFF, then send 8'h42 -> only 8'h42 is delivered.
REQ-039 With UART_RX_PARITY_EN, send 8'h07 with odd parity -> parity_err pulses and no data_valid; with correct parity -> 8'h07 is delivered.
